// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and default frame geometry,
// common to the transmitter and receiver datapaths.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  localparam int WORD_SIZE   = 8;
  localparam int OVER_SAMPLE = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; 2 clk latency, no backpressure.
// Both flops reset to 1 so a reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling on sampleTick, readReady/dataAck output register, parity option UART_RX_PARITY_EN.
// readReady rises 1 clk after the stop-bit sampleTick; a frame finishing while readReady is held is dropped and flags overrun.
module uart_rx
  import uart_pkg::*;
#(
  parameter int wordSize       = WORD_SIZE,
  parameter int sizeBitCount   = 3,
  parameter int overSample     = OVER_SAMPLE,
  parameter int overSampleBits = 3,
  parameter bit parityOdd      = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                serialIn,
  input  logic                sampleTick,
  input  logic                dataAck,
  output logic [wordSize-1:0] dataBus,
  output logic                readReady,
  output logic                errorFraming,
  output logic                errorParity,
  output logic                errorOverrun
);

  localparam int BCW = sizeBitCount + 1;
  localparam logic [overSampleBits-1:0] HALF_LAST = overSampleBits'(overSample / 2 - 1);
  localparam logic [overSampleBits-1:0] FULL_LAST = overSampleBits'(overSample - 1);
  localparam logic [BCW-1:0]            LAST_BIT  = BCW'(wordSize - 1);

  logic                      rx_in;
  logic                      frame_done;
  rx_state_t                 state_q, state_d;
  logic [overSampleBits-1:0] tick_cnt_q, tick_cnt_d;
  logic [BCW-1:0]            bit_cnt_q, bit_cnt_d;
  logic [wordSize-1:0]       shift_q, shift_d;
  logic [wordSize-1:0]       data_q, data_d;
  logic                      ready_q, ready_d;
  logic                      ferr_q, ferr_d;
  logic                      ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
  logic                      par_bad_q, par_bad_d;
  logic                      perr_q, perr_d;
`endif

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (serialIn),
    .sync_out (rx_in)
  );

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    ready_d    = ready_q;
    ferr_d     = ferr_q;
    ovr_d      = ovr_q;
    frame_done = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d  = par_bad_q;
    perr_d     = perr_q;
`endif

    if (sampleTick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_in) begin
            state_d    = ST_START;
            tick_cnt_d = '0;
          end
        end
        ST_START: begin
          if (tick_cnt_q == HALF_LAST) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rx_in ? ST_IDLE : ST_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = '0;
            shift_d    = {rx_in, shift_q[wordSize-1:1]};
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = '0;
            par_bad_d  = ((^shift_q) ^ rx_in) != parityOdd;
            state_d    = ST_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = '0;
            frame_done = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // An ack landing on the completion cycle frees the register for the new word.
    if (frame_done) begin
      if (!ready_q || dataAck) begin
        data_d  = shift_q;
        ready_d = 1'b1;
        ferr_d  = ~rx_in;
        ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = par_bad_q;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end else if (dataAck && ready_q) begin
      ready_d = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      ready_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= par_bad_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign dataBus      = data_q;
  assign readReady    = ready_q;
  assign errorFraming = ferr_q;
  assign errorOverrun = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign errorParity  = perr_q;
`else
  // Parity sense is irrelevant without a parity bit; the flag is constant 0.
  assign errorParity  = parityOdd & 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level reference model, directed scenarios and randomized frames.
module tb_uart_rx;

  localparam int BIT_CLK  = 32;  // 8 ticks per bit, one tick every 4 clk
  localparam int IDLE_CLK = 48;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk, rst, serialIn, sampleTick, dataAck;
  logic [7:0] dataBus;
  logic       readReady, errorFraming, errorParity, errorOverrun;

  int checks = 0;
  int errors = 0;

  logic       exp_rr, exp_fe, exp_pe, exp_ov;
  logic [7:0] exp_data;

  int   cyc = 0;
  int   cyc_stop = 0;
  int   rise_cyc = 0;
  logic tick_at_edge = 1'b0;
  logic rise_tick = 1'b0;
  logic rise_seen = 1'b0;
  logic rr_last = 1'b0;

  uart_rx dut (
    .clk          (clk),
    .rst          (rst),
    .serialIn     (serialIn),
    .sampleTick   (sampleTick),
    .dataAck      (dataAck),
    .dataBus      (dataBus),
    .readReady    (readReady),
    .errorFraming (errorFraming),
    .errorParity  (errorParity),
    .errorOverrun (errorOverrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    sampleTick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 sampleTick = 1'b1;
      @(posedge clk);
      #1 sampleTick = 1'b0;
    end
  end

  always @(posedge clk) begin
    cyc          <= cyc + 1;
    tick_at_edge <= sampleTick;
  end

  always @(negedge clk) begin
    if (readReady && !rr_last) begin
      rise_cyc  = cyc;
      rise_tick = tick_at_edge;
      rise_seen = 1'b1;
    end
    rr_last = readReady;
  end

  function automatic logic [11:0] obs();
    return {readReady, errorFraming, errorParity, errorOverrun, dataBus};
  endfunction

  function automatic logic [11:0] expv();
    return {exp_rr, exp_fe, exp_pe, exp_ov, exp_data};
  endfunction

  task automatic model_reset();
    exp_rr = 0; exp_fe = 0; exp_pe = 0; exp_ov = 0; exp_data = 8'h00;
  endtask

  // Frame-level rules: load when free, otherwise drop the word and flag overrun.
  task automatic model_frame(input logic [7:0] d, input logic stop, input logic par_bit);
    if (!exp_rr) begin
      exp_rr   = 1'b1;
      exp_data = d;
      exp_fe   = !stop;
      exp_pe   = PAR_EN && ((^{d, par_bit}) != 1'b0);
      exp_ov   = 1'b0;
    end else begin
      exp_ov = 1'b1;
    end
  endtask

  task automatic model_ack();
    if (exp_rr) begin
      exp_rr = 0; exp_fe = 0; exp_pe = 0; exp_ov = 0;
    end
  endtask

  task automatic drive_bit(input logic b);
    serialIn = b;
    repeat (BIT_CLK) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_bad);
    logic par_bit;
    par_bit = (^d) ^ par_bad;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit(par_bit);
    cyc_stop = cyc;
    drive_bit(stop);
    serialIn = 1'b1;
    repeat (IDLE_CLK) @(posedge clk);
    #1;
    model_frame(d, stop, par_bit);
  endtask

  task automatic do_ack();
    dataAck = 1'b1;
    @(posedge clk);
    #1 dataAck = 1'b0;
    model_ack();
  endtask

  task automatic test_reset();
    rst = 1'b1; serialIn = 1'b1; dataAck = 1'b0;
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (obs() !== expv()) begin errors++; $display("FAIL reset_state got %h want %h", obs(), expv()); end
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (obs() !== expv()) begin errors++; $display("FAIL post_reset_idle got %h want %h", obs(), expv()); end
  endtask

  task automatic test_basic();
    rise_seen = 1'b0;
    send_frame(8'hA5, 1'b1, 1'b0);
    checks++;
    if (obs() !== expv()) begin errors++; $display("FAIL frame_a5 got %h want %h", obs(), expv()); end
    checks++;
    if (!(rise_seen === 1'b1 && rise_tick === 1'b1 && (rise_cyc - cyc_stop) >= 17 && (rise_cyc - cyc_stop) <= 24)) begin
      errors++;
      $display("FAIL ready_latency got seen=%0b after_tick=%0b offset=%0d want seen=1 after_tick=1 offset 17..24",
               rise_seen, rise_tick, rise_cyc - cyc_stop);
    end
    do_ack();
    checks++;
    if (obs() !== expv()) begin errors++; $display("FAIL ack_a5 got %h want %h", obs(), expv()); end
  endtask

  task automatic test_false_start();
    serialIn = 1'b0;
    repeat (8) @(posedge clk);
    #1 serialIn = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    checks++;
    if (obs() !== expv()) begin errors++; $display("FAIL false_start got %h want %h", obs(), expv()); end
    send_frame(8'hC3, 1'b1, 1'b0);
    checks++;
    if (obs() !== expv()) begin errors++; $display("FAIL after_false_start got %h want %h", obs(), expv()); end
    do_ack();
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1'b0, 1'b0);
    checks++;
    if (obs() !== expv()) begin errors++; $display("FAIL framing_3c got %h want %h", obs(), expv()); end
    do_ack();
    checks++;
    if (obs() !== expv()) begin errors++; $display("FAIL framing_ack got %h want %h", obs(), expv()); end
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    checks++;
    if (obs() !== expv()) begin errors++; $display("FAIL overrun_hold got %h want %h", obs(), expv()); end
    do_ack();
    checks++;
    if (obs() !== expv()) begin errors++; $display("FAIL overrun_ack got %h want %h", obs(), expv()); end
    send_frame(8'h33, 1'b1, 1'b0);
    checks++;
    if (obs() !== expv()) begin errors++; $display("FAIL after_overrun got %h want %h", obs(), expv()); end
  endtask

  task automatic test_reset_mid_frame();
    // Leave 0x33 unacknowledged so the reset has something visible to clear.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    serialIn = 1'b1;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    checks++;
    if (obs() !== expv()) begin errors++; $display("FAIL mid_frame_reset got %h want %h", obs(), expv()); end
    repeat (BIT_CLK - 12) @(posedge clk);
    #1;
    for (int i = 5; i < 8; i++) drive_bit(1'b1);
    if (PAR_EN) drive_bit(1'b0);
    drive_bit(1'b1);
    repeat (IDLE_CLK) @(posedge clk);
    #1;
    checks++;
    if (obs() !== expv()) begin errors++; $display("FAIL aborted_frame_silent got %h want %h", obs(), expv()); end
    send_frame(8'h5A, 1'b1, 1'b0);
    checks++;
    if (obs() !== expv()) begin errors++; $display("FAIL frame_5a got %h want %h", obs(), expv()); end
    do_ack();
  endtask

  task automatic test_parity();
    send_frame(8'h07, 1'b1, 1'b0);
    checks++;
    if (obs() !== expv()) begin errors++; $display("FAIL parity_good got %h want %h", obs(), expv()); end
    do_ack();
    send_frame(8'h07, 1'b1, 1'b1);
    checks++;
    if (obs() !== expv()) begin errors++; $display("FAIL parity_bad got %h want %h", obs(), expv()); end
    do_ack();
    checks++;
    if (obs() !== expv()) begin errors++; $display("FAIL parity_ack got %h want %h", obs(), expv()); end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       stop, pbad;
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 2) != 0) begin
        do_ack();
        checks++;
        if (obs() !== expv()) begin errors++; $display("FAIL rand_ack[%0d] got %h want %h", n, obs(), expv()); end
      end
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      pbad = ($urandom_range(0, 3) == 0);
      send_frame(d, stop, pbad);
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL rand_frame[%0d] got %h want %h", n, obs(), expv()); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_framing();
    test_overrun();
    test_reset_mid_frame();
    test_parity();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
